fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage directly upstream of instr_memory.
//   - Owns the PC; drives imem_addr, consumes combinational imem_data (same-cycle read).
//   - Registers {pc, instr} into a single valid/ready output slot toward decode.
//   - Accepts redirects (branch/jump) from execute, a halt request, and flags a misaligned redirect.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded at reset (word-aligned)
//   COUNT_WIDTH  32             width of fetch_count
// PORTS
//   clk             input   1            single clock, rising edge
//   rst_n           input   1            reset, asynchronous assert, active-low
//   imem_addr       output  address_t    fetch address = pc_q (combinational from register)
//   imem_data       input   word_t       instruction word for imem_addr, same cycle
//   if_valid        output  1            output slot holds an instruction
//   if_ready        input   1            decode accepts the slot this cycle
//   if_instr        output  word_t       fetched instruction
//   if_pc           output  address_t    PC of if_instr
//   redirect_valid  input   1            execute requests PC change
//   redirect_pc     input   address_t    redirect target
//   halt            input   1            level: stop issuing new fetches
//   fetch_fault     output  1            sticky: misaligned redirect seen
//   fetch_count     output  COUNT_WIDTH  instructions loaded into the slot since reset
// BEHAVIOUR
//   Reset (rst_n=0, async): pc_q=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_fault=0,
//     fetch_count=0, state=RUN. Reset mid-operation discards the slot immediately.
//   slot_free = !if_valid || if_ready. Handshake: transfer when if_valid && if_ready.
//   if_instr/if_pc stable while if_valid && !if_ready.
//   FSM states: RUN, HALTED, FAULT. Per cycle, first matching rule wins:
//   1 state==FAULT: if_valid=0, pc_q holds, no fetch, redirects ignored; exit only via reset.
//   2 redirect_valid && redirect_pc[1:0]!=0: fetch_fault<=1, if_valid<=0, state<=FAULT.
//   3 redirect_valid (aligned): pc_q<=redirect_pc; if_valid<=0 (flush, slot dropped even if
//     if_ready=1 this cycle); no load this cycle; state <= halt ? HALTED : RUN.
//   4 halt: state<=HALTED; no new load; pending slot still drains on if_ready (if_valid<=0).
//   5 RUN/HALTED with !halt, slot_free: state<=RUN; if_instr<=imem_data, if_pc<=pc_q,
//     if_valid<=1, pc_q<=pc_q+4, fetch_count<=fetch_count+1.
//   6 otherwise (slot full, !if_ready): hold everything.
//   Latency: instr at PC P appears on if_instr one clk after pc_q==P with slot free.
//   Throughput: one instr/cycle while if_ready=1, no redirect, no halt.
//   First redirect target visible on if_valid 2 clks after redirect_valid.
//   Arithmetic: pc_q+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000);
//     fetch_count wraps modulo 2^COUNT_WIDTH.
//   pc_q[1:0] always 00; memory index aliasing (addr[9:2]) is the memory's concern.
//   halt deassert: fetch resumes at the held pc_q the next cycle, no PC skipped or repeated.
// TESTING
//   1 Reset, imem preloaded mem[k]=0x1000+k, if_ready=1 -> if_pc 0,4,8,... with if_instr
//     0x1000,0x1001,... back-to-back; fetch_count=3 after 3 loads.
//   2 if_ready=0 for 5 cycles after first load -> if_pc=0 / if_instr=0x1000 held, pc_q=4,
//     fetch_count=1; release -> if_pc=4 next.
//   3 redirect_valid, redirect_pc=0x40, same cycle as if_ready=1 -> slot flushed, if_valid=0
//     for one cycle, then if_pc=0x40, instr=mem[16].
//   4 halt=1 for 4 cycles mid-stream -> no loads, pending slot drains; halt=0 -> resumes at
//     held pc with no gap or duplicate.
//   5 redirect_pc=0x42 -> fetch_fault=1, if_valid=0 forever; later aligned redirects ignored;
//     rst_n pulse clears fault, pc_q=RESET_PC.
//   6 RESET_PC=32'hFFFF_FFF8, if_ready=1 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
//     Async rst_n low mid-stream -> if_valid=0 before the next clk edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a same-cycle instruction memory and
// presents {pc, instr} to decode through a single valid/ready slot.
//
// state   | meaning
// RUN     | fetching one instruction per free slot
// HALTED  | halt held: no new loads, pending slot may still drain
// FAULT   | misaligned redirect seen: fetch frozen until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [31:0]            o_imem_addr,
    input  logic [31:0]            i_imem_data,
    output logic                   o_if_valid,
    input  logic                   i_if_ready,
    output logic [31:0]            o_if_instr,
    output logic [31:0]            o_if_pc,
    input  logic                   i_redirect_valid,
    input  logic [31:0]            i_redirect_pc,
    input  logic                   i_halt,
    output logic                   o_fetch_fault,
    output logic [COUNT_WIDTH-1:0] o_fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [31:0]            r_pc, w_pc_nxt;
    logic                   r_valid, w_valid_nxt;
    logic [31:0]            r_instr, w_instr_nxt;
    logic [31:0]            r_ipc, w_ipc_nxt;
    logic                   r_fault, w_fault_nxt;
    logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                   w_slot_free;

    assign w_slot_free = !r_valid || i_if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= 32'h0;
            r_ipc   <= 32'h0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
            r_fault <= w_fault_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Priority: fault lock, misaligned redirect, redirect flush, halt, load, hold.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_fault_nxt = r_fault;
        w_count_nxt = r_count;
        if (r_state == ST_FAULT) begin
            w_valid_nxt = 1'b0;
        end else if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) begin
            w_fault_nxt = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_FAULT;
        end else if (i_redirect_valid) begin
            // Flush drops the slot even when decode is accepting it this cycle.
            w_pc_nxt    = i_redirect_pc;
            w_valid_nxt = 1'b0;
            w_state_nxt = i_halt ? ST_HALTED : ST_RUN;
        end else if (i_halt) begin
            w_state_nxt = ST_HALTED;
            if (i_if_ready) w_valid_nxt = 1'b0;
        end else if (w_slot_free) begin
            w_state_nxt = ST_RUN;
            w_instr_nxt = i_imem_data;
            w_ipc_nxt   = r_pc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_count_nxt = r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_if_valid    = r_valid;
    assign o_if_instr    = r_instr;
    assign o_if_pc       = r_ipc;
    assign o_fetch_fault = r_fault;
    assign o_fetch_count = r_count;

endmodule
